// File: rtl/special_case_resolver.sv
// Pipelined FMA special-case resolver: decides Inf/NaN/zero results
// from detector flags and delays them to match the datapath latency.
//
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   Valid_i, Stall_i      input valid, whole-pipe freeze
//   A_i, B_i, C_i         raw operands
//   {A,B,C}_{Inf,Zero,NaN,DeN}_i  operand classification flags
//   Prod_Neg_i, Sub_i     negate product, subtract addend
//   RM_i                  rounding mode (RDN selects -0 on exact cancel)
//   Valid_o, Special_o    output valid, result overrides datapath
//   Result_o, Invalid_o   special result word, NV flag
//   Empty_o               no valid entries in flight
module special_case_resolver #(
  parameter int PARM_XLEN       = 32,
  parameter int PARM_EXP        = 8,
  parameter int PARM_MANT       = 23,
  parameter int PARM_PIPE_DEPTH = 3,
  parameter logic [PARM_XLEN-1:0] PARM_CANON_NAN = 32'h7FC00000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 Valid_i,
  input  logic                 Stall_i,
  input  logic [PARM_XLEN-1:0] A_i,
  input  logic [PARM_XLEN-1:0] B_i,
  input  logic [PARM_XLEN-1:0] C_i,
  input  logic                 A_Inf_i,
  input  logic                 A_Zero_i,
  input  logic                 A_NaN_i,
  input  logic                 A_DeN_i,
  input  logic                 B_Inf_i,
  input  logic                 B_Zero_i,
  input  logic                 B_NaN_i,
  input  logic                 B_DeN_i,
  input  logic                 C_Inf_i,
  input  logic                 C_Zero_i,
  input  logic                 C_NaN_i,
  input  logic                 C_DeN_i,
  input  logic                 Prod_Neg_i,
  input  logic                 Sub_i,
  input  logic [2:0]           RM_i,
  output logic                 Valid_o,
  output logic                 Special_o,
  output logic [PARM_XLEN-1:0] Result_o,
  output logic                 Invalid_o,
  output logic                 Empty_o
);

  localparam int CW = $clog2(PARM_PIPE_DEPTH + 1);
  localparam logic [2:0] RM_RDN = 3'b010;

  if (PARM_XLEN != 1 + PARM_EXP + PARM_MANT) begin : g_bad_fmt
    $error("operand width must equal 1 + exponent + mantissa");
  end
  if (PARM_PIPE_DEPTH < 1 || PARM_PIPE_DEPTH > 8) begin : g_bad_depth
    $error("pipeline depth must be in 1..8");
  end

  typedef struct packed {
    logic                 valid;
    logic                 special;
    logic [PARM_XLEN-1:0] result;
    logic                 invalid;
  } stage_t;

  // DeN flags and the non-sign/non-quiet operand bits do not affect
  // the decision; only the sign, quiet bit and classification matter.
  logic unused_bits;
  assign unused_bits = ^{A_i, B_i, A_DeN_i, B_DeN_i, C_DeN_i};

  logic a_s, b_s, c_s;
  logic ps, cs;
  logic any_nan, any_snan;
  logic inf_zero;
  logic prod_inf, prod_zero;
  logic zero_sign;

  assign a_s = A_i[PARM_XLEN-1];
  assign b_s = B_i[PARM_XLEN-1];
  assign c_s = C_i[PARM_XLEN-1];
  assign ps  = a_s ^ b_s ^ Prod_Neg_i;
  assign cs  = c_s ^ Sub_i;

  assign any_nan  = A_NaN_i | B_NaN_i | C_NaN_i;
  assign any_snan = (A_NaN_i & ~A_i[PARM_MANT-1])
                  | (B_NaN_i & ~B_i[PARM_MANT-1])
                  | (C_NaN_i & ~C_i[PARM_MANT-1]);

  assign inf_zero  = (A_Inf_i & B_Zero_i) | (A_Zero_i & B_Inf_i);
  assign prod_inf  = A_Inf_i | B_Inf_i;
  assign prod_zero = A_Zero_i | B_Zero_i;

  // Exact cancellation of opposite-signed zeros gives -0 only in RDN.
  assign zero_sign = (ps == cs) ? ps : (RM_i == RM_RDN);

  logic                 sp0;
  logic                 inv0;
  logic [PARM_XLEN-1:0] res0;

  always_comb begin
    sp0  = 1'b0;
    inv0 = 1'b0;
    res0 = '0;
    if (any_nan || inf_zero) begin
      sp0  = 1'b1;
      res0 = PARM_CANON_NAN;
      inv0 = any_snan | inf_zero;
    end else if (prod_inf) begin
      sp0 = 1'b1;
      if (C_Inf_i && (cs != ps)) begin
        res0 = PARM_CANON_NAN;
        inv0 = 1'b1;
      end else begin
        res0 = {ps, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
      end
    end else if (C_Inf_i) begin
      sp0  = 1'b1;
      res0 = {cs, {PARM_EXP{1'b1}}, {PARM_MANT{1'b0}}};
    end else if (prod_zero && C_Zero_i) begin
      sp0  = 1'b1;
      res0 = {zero_sign, {(PARM_XLEN-1){1'b0}}};
    end else if (prod_zero) begin
      sp0  = 1'b1;
      res0 = {cs, C_i[PARM_XLEN-2:0]};
    end
  end

  stage_t s0;

  always_comb begin
    s0 = '0;
    if (Valid_i) begin
      s0.valid   = 1'b1;
      s0.special = sp0;
      s0.result  = res0;
      s0.invalid = inv0;
    end
  end

  stage_t pipe [PARM_PIPE_DEPTH];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < PARM_PIPE_DEPTH; i++) begin
        pipe[i] <= '0;
      end
    end else if (!Stall_i) begin
      pipe[0] <= s0;
      for (int i = 1; i < PARM_PIPE_DEPTH; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  logic [CW-1:0] count;
  logic          shift_in;
  logic          shift_out;

  assign shift_in  = Valid_i;
  assign shift_out = pipe[PARM_PIPE_DEPTH-1].valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count <= '0;
    end else if (!Stall_i) begin
      if (shift_in && !shift_out) begin
        count <= count + CW'(1);
      end else if (!shift_in && shift_out) begin
        count <= count - CW'(1);
      end
    end
  end

  assign Valid_o   = pipe[PARM_PIPE_DEPTH-1].valid;
  assign Special_o = pipe[PARM_PIPE_DEPTH-1].special;
  assign Result_o  = pipe[PARM_PIPE_DEPTH-1].result;
  assign Invalid_o = pipe[PARM_PIPE_DEPTH-1].invalid;
  assign Empty_o   = (count == '0);

endmodule

// File: tb/tb_special_case_resolver.sv
// Directed bench for special_case_resolver: table of vectors with
// hand-computed results plus stall and reset sequences.
module tb_special_case_resolver;

  localparam int D = 3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        Valid_i, Stall_i;
  logic [31:0] A_i, B_i, C_i;
  logic        A_Inf_i, A_Zero_i, A_NaN_i, A_DeN_i;
  logic        B_Inf_i, B_Zero_i, B_NaN_i, B_DeN_i;
  logic        C_Inf_i, C_Zero_i, C_NaN_i, C_DeN_i;
  logic        Prod_Neg_i, Sub_i;
  logic [2:0]  RM_i;
  logic        Valid_o, Special_o, Invalid_o, Empty_o;
  logic [31:0] Result_o;

  special_case_resolver #(.PARM_PIPE_DEPTH(D)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .Valid_i(Valid_i), .Stall_i(Stall_i),
    .A_i(A_i), .B_i(B_i), .C_i(C_i),
    .A_Inf_i(A_Inf_i), .A_Zero_i(A_Zero_i),
    .A_NaN_i(A_NaN_i), .A_DeN_i(A_DeN_i),
    .B_Inf_i(B_Inf_i), .B_Zero_i(B_Zero_i),
    .B_NaN_i(B_NaN_i), .B_DeN_i(B_DeN_i),
    .C_Inf_i(C_Inf_i), .C_Zero_i(C_Zero_i),
    .C_NaN_i(C_NaN_i), .C_DeN_i(C_DeN_i),
    .Prod_Neg_i(Prod_Neg_i), .Sub_i(Sub_i), .RM_i(RM_i),
    .Valid_o(Valid_o), .Special_o(Special_o),
    .Result_o(Result_o), .Invalid_o(Invalid_o),
    .Empty_o(Empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] a, b, c;
    logic        pn, sub;
    logic [2:0]  rm;
    logic        sp;
    logic [31:0] res;
    logic        inv;
  } vec_t;

  int nvec = 0;
  int nmis = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Upstream detector behaviour: {inf, zero, nan, den}.
  function automatic logic [3:0] cls(input logic [31:0] x);
    logic e1, e0, m0;
    e1 = (x[30:23] == 8'hFF);
    e0 = (x[30:23] == 8'h00);
    m0 = (x[22:0] == 23'h0);
    return {e1 & m0, e0 & m0, e1 & ~m0, e0 & ~m0};
  endfunction

  function automatic vec_t mk(input string n, input logic [31:0] a,
    input logic [31:0] b, input logic [31:0] c, input logic pn,
    input logic sub, input logic [2:0] rm, input logic sp,
    input logic [31:0] res, input logic inv);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.c = c;
    v.pn = pn; v.sub = sub; v.rm = rm;
    v.sp = sp; v.res = res; v.inv = inv;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    A_i = v.a; B_i = v.b; C_i = v.c;
    {A_Inf_i, A_Zero_i, A_NaN_i, A_DeN_i} = cls(v.a);
    {B_Inf_i, B_Zero_i, B_NaN_i, B_DeN_i} = cls(v.b);
    {C_Inf_i, C_Zero_i, C_NaN_i, C_DeN_i} = cls(v.c);
    Prod_Neg_i = v.pn; Sub_i = v.sub; RM_i = v.rm;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    Valid_i = 1'b1;
    @(posedge clk_i); #1;
    Valid_i = 1'b0;
    chk({v.name, ".early"}, {31'b0, Valid_o}, 32'd0);
    chk({v.name, ".busy"}, {31'b0, Empty_o}, 32'd0);
    repeat (D-1) @(posedge clk_i);
    #1;
    chk({v.name, ".valid"}, {31'b0, Valid_o}, 32'd1);
    chk({v.name, ".special"}, {31'b0, Special_o}, {31'b0, v.sp});
    chk({v.name, ".result"}, Result_o, v.res);
    chk({v.name, ".invalid"}, {31'b0, Invalid_o}, {31'b0, v.inv});
    @(posedge clk_i); #1;
    chk({v.name, ".drain"}, {31'b0, Valid_o}, 32'd0);
    chk({v.name, ".empty"}, {31'b0, Empty_o}, 32'd1);
  endtask

  vec_t tbl [16];
  vec_t ops [3];
  int   idx;
  int   stale;

  initial begin
    tbl[0]  = mk("inf_x_zero", 32'h7F800000, 32'h00000000,
                 32'h3F800000, 0, 0, 3'b000, 1, 32'h7FC00000, 1);
    tbl[1]  = mk("inf_minus_inf", 32'h7F800000, 32'h3F800000,
                 32'hFF800000, 0, 0, 3'b000, 1, 32'h7FC00000, 1);
    tbl[2]  = mk("inf_plus_inf", 32'h7F800000, 32'h3F800000,
                 32'hFF800000, 0, 1, 3'b000, 1, 32'h7F800000, 0);
    tbl[3]  = mk("zero_rne", 32'h00000000, 32'h40000000,
                 32'h80000000, 0, 0, 3'b000, 1, 32'h00000000, 0);
    tbl[4]  = mk("zero_rdn", 32'h00000000, 32'h40000000,
                 32'h80000000, 0, 0, 3'b010, 1, 32'h80000000, 0);
    tbl[5]  = mk("snan_c", 32'h3F800000, 32'h40000000,
                 32'h7F800001, 0, 0, 3'b000, 1, 32'h7FC00000, 1);
    tbl[6]  = mk("qnan_c", 32'h3F800000, 32'h40000000,
                 32'h7FC00001, 0, 0, 3'b000, 1, 32'h7FC00000, 0);
    tbl[7]  = mk("normal", 32'h3F800000, 32'h40000000,
                 32'h40400000, 0, 0, 3'b000, 0, 32'h00000000, 0);
    tbl[8]  = mk("c_inf_neg", 32'h3F800000, 32'h40000000,
                 32'hFF800000, 0, 0, 3'b000, 1, 32'hFF800000, 0);
    tbl[9]  = mk("zero_prod_c", 32'h00000000, 32'h40400000,
                 32'h3F800000, 0, 1, 3'b000, 1, 32'hBF800000, 0);
    tbl[10] = mk("den_a", 32'h00000001, 32'h3F800000,
                 32'h3F800000, 0, 0, 3'b000, 0, 32'h00000000, 0);
    tbl[11] = mk("neg_zeros", 32'h80000000, 32'h00000000,
                 32'h80000000, 0, 0, 3'b000, 1, 32'h80000000, 0);
    tbl[12] = mk("inf_pneg", 32'h7F800000, 32'h3F800000,
                 32'h00000000, 1, 0, 3'b000, 1, 32'hFF800000, 0);
    tbl[13] = mk("zero_prod_den_c", 32'h00000000, 32'h3F800000,
                 32'h00000010, 0, 0, 3'b000, 1, 32'h00000010, 0);
    tbl[14] = mk("snan_a", 32'h7F800001, 32'h3F800000,
                 32'h3F800000, 0, 0, 3'b000, 1, 32'h7FC00000, 1);
    tbl[15] = mk("zero_x_inf_qnan", 32'h80000000, 32'hFF800000,
                 32'h7FC00000, 0, 0, 3'b000, 1, 32'h7FC00000, 1);

    rst_i = 1'b1; Valid_i = 1'b0; Stall_i = 1'b0;
    drive(tbl[7]);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.valid", {31'b0, Valid_o}, 32'd0);
    chk("rst.special", {31'b0, Special_o}, 32'd0);
    chk("rst.result", Result_o, 32'd0);
    chk("rst.invalid", {31'b0, Invalid_o}, 32'd0);
    chk("rst.empty", {31'b0, Empty_o}, 32'd1);
    rst_i = 1'b0;

    for (int i = 0; i < 16; i++) begin
      run_vec(tbl[i]);
    end

    // Three back-to-back ops with a 2-cycle stall after the first.
    ops[0] = tbl[0];
    ops[1] = tbl[2];
    ops[2] = tbl[7];
    drive(ops[0]); Valid_i = 1'b1;
    @(posedge clk_i); #1;
    drive(ops[1]); Stall_i = 1'b1;
    @(posedge clk_i); #1;
    chk("stall.busy", {31'b0, Empty_o}, 32'd0);
    @(posedge clk_i); #1;
    chk("stall.hold", {31'b0, Valid_o}, 32'd0);
    chk("stall.busy2", {31'b0, Empty_o}, 32'd0);
    Stall_i = 1'b0;
    @(posedge clk_i); #1;
    drive(ops[2]);
    @(posedge clk_i); #1;
    Valid_i = 1'b0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      if (Valid_o) begin
        if (idx < 3) begin
          chk($sformatf("stall.res%0d", idx), Result_o, ops[idx].res);
          chk($sformatf("stall.sp%0d", idx), {31'b0, Special_o},
              {31'b0, ops[idx].sp});
          chk($sformatf("stall.inv%0d", idx), {31'b0, Invalid_o},
              {31'b0, ops[idx].inv});
        end
        idx++;
      end
      @(posedge clk_i); #1;
    end
    chk("stall.pulses", idx, 32'd3);
    chk("stall.empty", {31'b0, Empty_o}, 32'd1);

    // Stall while a result sits at the output: it must be held.
    drive(tbl[8]); Valid_i = 1'b1;
    @(posedge clk_i); #1;
    Valid_i = 1'b0;
    repeat (D-1) @(posedge clk_i);
    #1;
    Stall_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("hold.valid", {31'b0, Valid_o}, 32'd1);
    chk("hold.result", Result_o, 32'hFF800000);
    chk("hold.busy", {31'b0, Empty_o}, 32'd0);
    Stall_i = 1'b0;
    @(posedge clk_i); #1;
    chk("hold.drain", {31'b0, Valid_o}, 32'd0);
    chk("hold.empty", {31'b0, Empty_o}, 32'd1);

    // Reset with two ops in flight.
    drive(tbl[0]); Valid_i = 1'b1;
    @(posedge clk_i); #1;
    drive(tbl[8]);
    @(posedge clk_i); #1;
    Valid_i = 1'b0; rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    chk("midrst.valid", {31'b0, Valid_o}, 32'd0);
    chk("midrst.result", Result_o, 32'd0);
    chk("midrst.empty", {31'b0, Empty_o}, 32'd1);
    stale = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_i); #1;
      if (Valid_o) stale++;
    end
    chk("midrst.stale", stale, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/special_case_resolver.md
# special_case_resolver

Pipelined special-case resolver for the FMA datapath (R = ±(A·B) ± C), placed directly downstream of the operand special-case detector. It consumes the per-operand Inf/Zero/NaN/DeN flags and the raw operands. It decides whether the result is fully determined without the multiply/add/normalise datapath and, if so, produces the IEEE-754 result word and the invalid-operation flag. The decision is delayed through a stallable shift pipeline so it arrives on the same cycle as the main datapath result, which it overrides when `Special_o` is high.

## Interface
- `PARM_XLEN`, default 32: operand/result width.
- `PARM_EXP`, default 8: exponent field width.
- `PARM_MANT`, default 23: stored mantissa width.
- `PARM_PIPE_DEPTH`, default 3: latency in cycles; legal range 1..8; must equal the main datapath latency.
- `PARM_CANON_NAN`, default 32'h7FC00000: canonical quiet NaN.
- `clk_i` input 1: clock.
- `rst_i` input 1: synchronous, active-high reset.
- `Valid_i` input 1: operands and flags valid this cycle.
- `Stall_i` input 1: freeze the whole pipeline.
- `A_i`, `B_i`, `C_i` input PARM_XLEN each: raw operands.
- `A_Inf_i`, `A_Zero_i`, `A_NaN_i`, `A_DeN_i` input 1 each: A classification from the detector.
- `B_Inf_i`, `B_Zero_i`, `B_NaN_i`, `B_DeN_i` input 1 each: B classification.
- `C_Inf_i`, `C_Zero_i`, `C_NaN_i`, `C_DeN_i` input 1 each: C classification.
- `Prod_Neg_i` input 1: negate product (fnmadd/fnmsub).
- `Sub_i` input 1: subtract C (fmsub/fnmadd).
- `RM_i` input 3: RISC-V rounding mode (3'b010 = RDN).
- `Valid_o` output 1: outputs valid.
- `Special_o` output 1: `Result_o` overrides the datapath.
- `Result_o` output PARM_XLEN: special result; 0 when `Special_o` = 0.
- `Invalid_o` output 1: NV exception flag.
- `Empty_o` output 1: no valid entries in flight.

## Operation
- Definitions:
  - Ps = A_sign ^ B_sign ^ Prod_Neg_i.
  - Cs = C_sign ^ Sub_i.
  - sNaN = NaN flag set and mantissa MSB (bit PARM_MANT-1) = 0.
- Resolution is combinational at stage 0 and evaluated in strict priority order:
  1. Any NaN flag, or (A_Inf & B_Zero) or (A_Zero & B_Inf): Result = PARM_CANON_NAN. Invalid = any sNaN | Inf·0.
  2. A_Inf or B_Inf:
     - if C_Inf and Cs ≠ Ps: canonical NaN, Invalid = 1;
     - otherwise: Inf with sign Ps.
  3. C_Inf: Inf with sign Cs.
  4. (A_Zero or B_Zero) and C_Zero: signed zero. Sign = Ps if Ps == Cs, else (RM_i == 3'b010).
  5. (A_Zero or B_Zero), C nonzero finite (including DeN): Result = {Cs, C_i[PARM_XLEN-2:0]}.
  6. Otherwise: Special = 0, Result = 0, Invalid = 0.
- In every case 1–5, Special = 1. Invalid = 0 unless stated above. DeN flags only mark nonzero finite values; a DeN operand never itself makes a result special.
- Stage 0 result {valid, special, result, invalid} enters a PARM_PIPE_DEPTH-entry shift register. Outputs are driven from the last entry (registered outputs).
- Occupancy counter (width ⌈log2(PARM_PIPE_DEPTH+1)⌉):
  - increments on shift-in of a valid entry;
  - decrements on shift-out of a valid entry;
  - both in the same cycle leaves it unchanged.
- `Empty_o` = (count == 0).

## Timing
- Reset:
  - all stages cleared (valid = 0, data = 0);
  - `Valid_o`, `Special_o`, `Invalid_o` = 0;
  - `Result_o` = 0;
  - count = 0, `Empty_o` = 1.
- Reset takes priority over `Stall_i` and `Valid_i`. Reset mid-flight discards all entries on that edge.
- Latency: an operand accepted at edge n (Valid_i = 1, Stall_i = 0) appears at `Valid_o` after edge n+PARM_PIPE_DEPTH−1. Each stalled cycle adds one cycle.
- Stall_i = 1: no stage updates, `Valid_i` is ignored (upstream holds it), and outputs and count are held.
- Stall_i = 0: the pipe shifts every cycle. A bubble (Valid_i = 0) enters as valid = 0 with zeroed data.
- Throughput: one operation per unstalled cycle; order preserved; no drops or duplicates.
- Count never exceeds PARM_PIPE_DEPTH and never underflows.

## Test plan
- **Inf·0:** A = 0x7F800000, B = 0x00000000, C = 0x3F800000, Valid_i pulse, depth 3 → 3 edges later Valid_o = 1, Special_o = 1, Result_o = 0x7FC00000, Invalid_o = 1.
- **Inf − Inf:** A = 0x7F800000, B = 0x3F800000, C = 0xFF800000, Sub_i = 0 → 0x7FC00000, Invalid_o = 1. Same operands with Sub_i = 1 → 0x7F800000, Invalid_o = 0.
- **Signed zero:** A = 0x00000000, B = 0x40000000, C = 0x80000000. RM_i = 3'b000 → 0x00000000; RM_i = 3'b010 → 0x80000000; Invalid_o = 0 in both.
- **NaN signalling:** C = 0x7F800001 → 0x7FC00000 with Invalid_o = 1. C = 0x7FC00001 → 0x7FC00000 with Invalid_o = 0. Normal operands (1.0·2.0 + 3.0) → Special_o = 0, Result_o = 0.
- **Stall:** three back-to-back ops, Stall_i high 2 cycles starting one cycle after the first → outputs frozen during the stall, results in original order, exactly 3 Valid_o pulses, Empty_o returns to 1.
- **Reset mid-flight:** two ops in flight, rst_i high one cycle → next cycle Valid_o = 0, Empty_o = 1; no stale result ever appears.
